npu_burst_mem_slave: RTL and testbench

- Avalon-MM burst responder, on-chip 32-bit scratchpad. Terminates the NPU DMA read master and write master: independent read port and write port onto one dual-port word RAM.
- Serves as the target memory in the NPU subsystem bench and as local SRAM in the integrated design.
- Optional periodic waitrequest injection exercises DMA backpressure handling.

---
 rtl/npu_burst_mem_slave.sv | 108 ++++++++++
 tb/tb_npu_burst_mem_slave.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/npu_burst_mem_slave.sv
// npu_burst_mem_slave: Avalon-MM burst responder over a dual-port 32-bit scratchpad
// with independent read/write ports and optional periodic waitrequest injection.
module npu_burst_mem_slave #(
    parameter int DEPTH        = 1024,
    parameter int AW           = 10,
    parameter int STALL_PERIOD = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rd_s_address,
    input  logic [9:0]  rd_s_burstcount,
    input  logic        rd_s_read,
    output logic        rd_s_waitrequest,
    output logic [31:0] rd_s_readdata,
    output logic        rd_s_readdatavalid,
    input  logic [31:0] wr_s_address,
    input  logic [9:0]  wr_s_burstcount,
    input  logic        wr_s_write,
    input  logic [31:0] wr_s_writedata,
    output logic        wr_s_waitrequest,
    output logic        busy
);
    localparam int CW = STALL_PERIOD > 0 ? $clog2(STALL_PERIOD + 1) : 1;
    localparam logic [CW-1:0] SP = CW'(STALL_PERIOD);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_DRAIN} rd_state_t;
    typedef enum logic {W_IDLE, W_BURST} wr_state_t;

    rd_state_t     rd_state;
    wr_state_t     wr_state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_q;
    logic [AW-1:0] rd_ptr, wr_ptr, wr_addr;
    logic [9:0]    rd_rem, wr_rem, wr_rem_next;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic          rd_stall, wr_stall, rd_issue, rd_pend, wr_accept;
    logic          unused_bits;

    assign rd_stall         = (STALL_PERIOD > 0) && (rd_cnt == SP);
    assign wr_stall         = (STALL_PERIOD > 0) && (wr_cnt == SP);
    assign rd_issue         = (rd_state == R_ISSUE) && !rd_stall;
    assign wr_accept        = wr_s_write && !wr_stall;
    assign wr_addr          = (wr_state == W_IDLE) ? wr_s_address[AW+1:2] : wr_ptr + 1'b1;
    assign wr_rem_next      = (wr_state == W_IDLE) ? ((wr_s_burstcount == 10'd0) ? 10'd0 : wr_s_burstcount - 10'd1)
                                                   : wr_rem - 10'd1;
    assign rd_s_waitrequest = (rd_state != R_IDLE);
    assign wr_s_waitrequest = wr_stall;
    assign busy             = (rd_state != R_IDLE) || (wr_state != W_IDLE);
    assign unused_bits      = ^{rd_s_address[31:AW+2], rd_s_address[1:0], wr_s_address[31:AW+2], wr_s_address[1:0]};

    // Non-blocking read and write of the same word in one cycle yields the old word.
    always_ff @(posedge clk) begin
        if (rd_issue) rd_q <= mem[rd_ptr];
        if (wr_accept) mem[wr_addr] <= wr_s_writedata;
    end

    // Two-stage read pipe: RAM register, then output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state           <= R_IDLE;
            rd_ptr             <= '0;
            rd_rem             <= '0;
            rd_cnt             <= '0;
            rd_pend            <= 1'b0;
            rd_s_readdatavalid <= 1'b0;
            rd_s_readdata      <= '0;
        end else begin
            rd_pend            <= rd_issue;
            rd_s_readdatavalid <= rd_pend;
            if (rd_pend) rd_s_readdata <= rd_q;
            if (rd_state == R_IDLE) begin
                if (rd_s_read && rd_s_burstcount != 10'd0) begin
                    rd_ptr   <= rd_s_address[AW+1:2];
                    rd_rem   <= rd_s_burstcount;
                    rd_state <= R_ISSUE;
                end
            end else if (rd_state == R_ISSUE) begin
                if (rd_stall) begin
                    rd_cnt <= '0;
                end else begin
                    rd_ptr <= rd_ptr + 1'b1;
                    rd_rem <= rd_rem - 10'd1;
                    rd_cnt <= rd_cnt + 1'b1;
                    if (rd_rem == 10'd1) rd_state <= R_DRAIN;
                end
            end else begin
                if (!rd_pend) rd_state <= R_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state <= W_IDLE;
            wr_ptr   <= '0;
            wr_rem   <= '0;
            wr_cnt   <= '0;
        end else begin
            if (wr_stall) wr_cnt <= '0;
            else if (wr_accept) wr_cnt <= wr_cnt + 1'b1;
            if (wr_accept) begin
                wr_ptr   <= wr_addr;
                wr_rem   <= wr_rem_next;
                wr_state <= (wr_rem_next != 10'd0) ? W_BURST : W_IDLE;
            end
        end
    end
endmodule

// File: tb/tb_npu_burst_mem_slave.sv
// tb_npu_burst_mem_slave: directed bench with a cycle-level reference model of both
// ports, checked every cycle, plus literal expectations for each scenario.
module tb_npu_burst_mem_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] rd_address [2];
    logic [31:0] rd_data    [2];
    logic [31:0] wr_address [2];
    logic [31:0] wr_data    [2];
    logic [9:0]  rd_bc      [2];
    logic [9:0]  wr_bc      [2];
    logic        rd_read    [2];
    logic        rd_wait    [2];
    logic        rd_valid   [2];
    logic        wr_write   [2];
    logic        wr_wait    [2];
    logic        busy_o     [2];

    npu_burst_mem_slave #(.DEPTH(1024), .AW(10), .STALL_PERIOD(0)) d0 (
        .clk(clk), .rst(rst),
        .rd_s_address(rd_address[0]), .rd_s_burstcount(rd_bc[0]), .rd_s_read(rd_read[0]),
        .rd_s_waitrequest(rd_wait[0]), .rd_s_readdata(rd_data[0]), .rd_s_readdatavalid(rd_valid[0]),
        .wr_s_address(wr_address[0]), .wr_s_burstcount(wr_bc[0]), .wr_s_write(wr_write[0]),
        .wr_s_writedata(wr_data[0]), .wr_s_waitrequest(wr_wait[0]), .busy(busy_o[0]));

    npu_burst_mem_slave #(.DEPTH(1024), .AW(10), .STALL_PERIOD(2)) d2 (
        .clk(clk), .rst(rst),
        .rd_s_address(rd_address[1]), .rd_s_burstcount(rd_bc[1]), .rd_s_read(rd_read[1]),
        .rd_s_waitrequest(rd_wait[1]), .rd_s_readdata(rd_data[1]), .rd_s_readdatavalid(rd_valid[1]),
        .wr_s_address(wr_address[1]), .wr_s_burstcount(wr_bc[1]), .wr_s_write(wr_write[1]),
        .wr_s_writedata(wr_data[1]), .wr_s_waitrequest(wr_wait[1]), .busy(busy_o[1]));

    int          cyc = 0;
    bit          armed = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_mem [2][1024];
    int          rb_until [2];
    int          r_cnt [2];
    int          w_rem [2];
    int          w_ptr [2];
    int          w_cnt [2];
    bit          ev_v [2][64];
    logic [31:0] ev_d [2][64];
    logic [31:0] last_d [2];
    logic [31:0] gq0_d [$];
    logic [31:0] gq1_d [$];
    int          gq0_c [$];
    int          gq1_c [$];
    int          wacc [$];
    logic [31:0] wbuf [16];
    logic [31:0] xd [16];
    int          xo [16];
    int          last_acc;
    int          acc2;

    function automatic int per(input int d);
        return d == 0 ? 0 : 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%h required=%h cycle=%0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: read bursts become a schedule of (cycle, data) beats; writes update a word array.
    always @(posedge clk) begin
        cyc = cyc + 1;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                armed = 1;
                rb_until[d] = -1;
                r_cnt[d] = 0;
                w_rem[d] = 0;
                w_ptr[d] = 0;
                w_cnt[d] = 0;
                last_d[d] = '0;
                for (int j = 0; j < 64; j++) ev_v[d][j] = 0;
            end else begin
                if (rd_read[d] && cyc - 1 > rb_until[d] && rd_bc[d] != 0) begin
                    int t;
                    int p;
                    t = cyc + 2;
                    p = int'(rd_address[d][11:2]);
                    for (int i = 0; i < int'(rd_bc[d]); i++) begin
                        if (per(d) > 0 && r_cnt[d] == per(d)) begin
                            t++;
                            r_cnt[d] = 0;
                        end
                        ev_v[d][t % 64] = 1;
                        ev_d[d][t % 64] = m_mem[d][(p + i) % 1024];
                        t++;
                        r_cnt[d]++;
                    end
                    rb_until[d] = t - 1;
                end
                if (per(d) > 0 && w_cnt[d] == per(d)) begin
                    w_cnt[d] = 0;
                end else if (wr_write[d]) begin
                    int a;
                    a = (w_rem[d] == 0) ? int'(wr_address[d][11:2]) : (w_ptr[d] + 1) % 1024;
                    m_mem[d][a] = wr_data[d];
                    w_ptr[d] = a;
                    w_rem[d] = (w_rem[d] == 0) ? ((wr_bc[d] == 0) ? 0 : int'(wr_bc[d]) - 1) : w_rem[d] - 1;
                    w_cnt[d]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            for (int d = 0; d < 2; d++) begin
                bit          ev;
                logic [31:0] ed;
                ev = ev_v[d][cyc % 64];
                ed = ev ? ev_d[d][cyc % 64] : last_d[d];
                last_d[d] = ed;
                ev_v[d][cyc % 64] = 0;
                chk($sformatf("rd_valid[%0d]", d), 32'(rd_valid[d]), 32'(ev));
                chk($sformatf("rd_data[%0d]", d), rd_data[d], ed);
                chk($sformatf("rd_wait[%0d]", d), 32'(rd_wait[d]), 32'(cyc <= rb_until[d]));
                chk($sformatf("wr_wait[%0d]", d), 32'(wr_wait[d]), 32'(per(d) > 0 && w_cnt[d] == per(d)));
                chk($sformatf("busy[%0d]", d), 32'(busy_o[d]), 32'(cyc <= rb_until[d] || w_rem[d] > 0));
                if (rd_valid[d] === 1'b1) begin
                    if (d == 0) begin
                        gq0_d.push_back(rd_data[d]);
                        gq0_c.push_back(cyc);
                    end else begin
                        gq1_d.push_back(rd_data[d]);
                        gq1_c.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic wr_burst(input int d, input logic [31:0] a, input logic [9:0] bc, input int n,
                            input int gap_at, input int gap_len);
        int i;
        int g;
        int t;
        bit acc;
        i = 0;
        g = 0;
        t = 0;
        while (i < n && t < 100) begin
            @(negedge clk);
            if (i == gap_at && g < gap_len) begin
                wr_write[d] = 1'b0;
                g++;
                chk("gap_busy", 32'(busy_o[d]), 32'd1);
            end else begin
                wr_write[d] = 1'b1;
                wr_address[d] = a;
                wr_bc[d] = bc;
                wr_data[d] = wbuf[i];
                acc = !wr_wait[d];
                @(posedge clk);
                if (acc) begin
                    wacc.push_back(t);
                    i++;
                end
            end
            t++;
        end
        chk("wr_beats_done", 32'(i), 32'(n));
        @(negedge clk);
        wr_write[d] = 1'b0;
    endtask

    task automatic rd_burst(input int d, input logic [31:0] a, input logic [9:0] bc);
        int n;
        n = 0;
        @(negedge clk);
        rd_read[d] = 1'b1;
        rd_address[d] = a;
        rd_bc[d] = bc;
        while (rd_wait[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rd_accept_timeout", 32'(n >= 50), 32'd0);
        @(negedge clk);
        rd_read[d] = 1'b0;
        last_acc = cyc;
    endtask

    task automatic settle(input int d);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy_o[d] || rd_wait[d]) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("settle_timeout", 32'(n >= 200), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic expect_rd(input string nm, input int d, input int n, input int base);
        int sz;
        sz = (d == 0) ? gq0_d.size() : gq1_d.size();
        chk({nm, "_count"}, 32'(sz), 32'(n));
        for (int i = 0; i < n && i < sz; i++) begin
            chk({nm, "_data"}, (d == 0) ? gq0_d[i] : gq1_d[i], xd[i]);
            chk({nm, "_cycle"}, 32'(((d == 0) ? gq0_c[i] : gq1_c[i]) - base), 32'(xo[i]));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rd_read[d] = 1'b0;
            wr_write[d] = 1'b0;
            rd_address[d] = '0;
            wr_address[d] = '0;
            rd_bc[d] = '0;
            wr_bc[d] = '0;
            wr_data[d] = '0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // basic burst: write 0x11..0x44, read back with first beat at accept+2
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h11 * (i + 1);
        wr_burst(0, 32'h0, 10'd4, 4, -1, 0);
        settle(0);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h0, 10'd4);
        settle(0);
        xd[0] = 32'h11; xd[1] = 32'h22; xd[2] = 32'h33; xd[3] = 32'h44;
        xo[0] = 2; xo[1] = 3; xo[2] = 4; xo[3] = 5;
        expect_rd("basic", 0, 4, last_acc);

        // address wrap at the top of the array
        wbuf[0] = 32'hA0A0_000A; wbuf[1] = 32'hB0B0_000B; wbuf[2] = 32'hC0C0_000C;
        wr_burst(0, 32'hFF8, 10'd3, 3, -1, 0);
        settle(0);
        chk("model_w1022", m_mem[0][1022], 32'hA0A0_000A);
        chk("model_w0", m_mem[0][0], 32'hC0C0_000C);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'hFF8, 10'd3);
        settle(0);
        xd[0] = 32'hA0A0_000A; xd[1] = 32'hB0B0_000B; xd[2] = 32'hC0C0_000C;
        xo[0] = 2; xo[1] = 3; xo[2] = 4;
        expect_rd("wrap", 0, 3, last_acc);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h0, 10'd1);
        settle(0);
        xd[0] = 32'hC0C0_000C; xo[0] = 2;
        expect_rd("wrap_w0", 0, 1, last_acc);

        // master stall: three idle cycles between beats 2 and 3
        for (int i = 0; i < 4; i++) wbuf[i] = 32'h3000_0000 + i;
        wr_burst(0, 32'h40, 10'd4, 4, 2, 3);
        settle(0);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h40, 10'd4);
        settle(0);
        for (int i = 0; i < 4; i++) begin
            xd[i] = 32'h3000_0000 + i;
            xo[i] = i + 2;
        end
        expect_rd("mstall", 0, 4, last_acc);

        // collision: read of word 5 issued on the same edge a write to word 5 commits
        wbuf[0] = 32'hAAAA;
        wr_burst(0, 32'h14, 10'd1, 1, -1, 0);
        settle(0);
        gq0_d.delete(); gq0_c.delete();
        @(negedge clk);
        rd_read[0] = 1'b1; rd_address[0] = 32'h14; rd_bc[0] = 10'd1;
        @(negedge clk);
        rd_read[0] = 1'b0; last_acc = cyc;
        wr_write[0] = 1'b1; wr_address[0] = 32'h14; wr_bc[0] = 10'd1; wr_data[0] = 32'hBBBB;
        @(negedge clk);
        wr_write[0] = 1'b0;
        settle(0);
        xd[0] = 32'hAAAA; xo[0] = 2;
        expect_rd("collide_old", 0, 1, last_acc);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h14, 10'd1);
        settle(0);
        xd[0] = 32'hBBBB;
        expect_rd("collide_new", 0, 1, last_acc);

        // reset during beat 2 of an 8-beat read, new read right after reset
        for (int i = 0; i < 8; i++) wbuf[i] = 32'h100 + i;
        wr_burst(0, 32'h190, 10'd8, 8, -1, 0);
        settle(0);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h190, 10'd8);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        rd_read[0] = 1'b1; rd_address[0] = 32'h0; rd_bc[0] = 10'd1;
        @(negedge clk);
        rd_read[0] = 1'b0; acc2 = cyc;
        settle(0);
        xd[0] = 32'h100; xd[1] = 32'h101; xd[2] = 32'hC0C0_000C;
        xo[0] = 2; xo[1] = 3; xo[2] = acc2 + 2 - last_acc;
        expect_rd("rst_mid", 0, 3, last_acc);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h190, 10'd8);
        settle(0);
        for (int i = 0; i < 8; i++) begin
            xd[i] = 32'h100 + i;
            xo[i] = i + 2;
        end
        expect_rd("rst_survive", 0, 8, last_acc);
        gq0_d.delete(); gq0_c.delete();
        rd_burst(0, 32'h0, 10'd0);
        repeat (6) @(negedge clk);
        chk("bc0_no_data", 32'(gq0_d.size()), 32'd0);

        // backpressure on the STALL_PERIOD=2 instance
        for (int i = 0; i < 6; i++) wbuf[i] = 32'h61 + i;
        wacc.delete();
        wr_burst(1, 32'h0, 10'd6, 6, -1, 0);
        settle(1);
        chk("bp_wacc_n", 32'(wacc.size()), 32'd6);
        if (wacc.size() == 6) begin
            chk("bp_wacc1", 32'(wacc[1] - wacc[0]), 32'd1);
            chk("bp_wacc2", 32'(wacc[2] - wacc[0]), 32'd3);
            chk("bp_wacc3", 32'(wacc[3] - wacc[0]), 32'd4);
            chk("bp_wacc4", 32'(wacc[4] - wacc[0]), 32'd6);
            chk("bp_wacc5", 32'(wacc[5] - wacc[0]), 32'd7);
        end
        gq1_d.delete(); gq1_c.delete();
        rd_burst(1, 32'h0, 10'd6);
        settle(1);
        for (int i = 0; i < 6; i++) xd[i] = 32'h61 + i;
        xo[0] = 2; xo[1] = 3; xo[2] = 5; xo[3] = 6; xo[4] = 8; xo[5] = 9;
        expect_rd("bp_read", 1, 6, last_acc);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
